// File: rtl/sort_fsm_pkg.sv
// Shared definitions for the N-element FSM float sorter.
// FLEN mirrors the codebase-wide FP64 element width.
package sort_fsm_pkg;

   localparam int unsigned FLEN = 64;

   typedef enum logic [1:0] {
      IDLE,
      CMP,
      DONE
   } sort_state_t;

endpackage

// File: rtl/sort_floats_n_using_fsm.sv
// Bubble sorter for N FP64 values through one external f_less_or_equal comparator,
// one comparison per clock, with ascending/descending mode, early exit and abort-on-error.
module sort_floats_n_using_fsm
   import sort_fsm_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       valid_in,
   input  logic                       descending,
   input  logic [0:N-1][FLEN-1:0]     unsorted,
   output logic                       valid_out,
   output logic [0:N-1][FLEN-1:0]     sorted,
   output logic                       err,
   output logic                       busy,
   output logic [FLEN-1:0]            f_le_a,
   output logic [FLEN-1:0]            f_le_b,
   input  logic                       f_le_res,
   input  logic                       f_le_err
);

   localparam int unsigned JW = $clog2(N);
   localparam logic [JW-1:0] LAST_P = JW'(N - 2);

   sort_state_t state, state_nx;

   logic [0:N-1][FLEN-1:0] w;
   logic [JW-1:0]          j, p, j_nx, last_j;
   logic                   desc_q, swapped, err_sticky;
   logic                   swap, last_pair, final_pass, pass_clean;

   assign j_nx       = j + JW'(1);
   assign last_j     = LAST_P - p;
   assign last_pair  = (j == last_j);
   assign final_pass = (p == LAST_P);
   assign swap       = !f_le_res;
   assign pass_clean = !(swapped | swap);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (valid_in) state_nx = CMP;
         CMP: begin
            if (f_le_err)
               state_nx = DONE;
            else if (last_pair && (final_pass || pass_clean))
               state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Descending mode reuses the same <= comparator by presenting the pair reversed.
   always_comb begin
      busy   = (state != IDLE);
      f_le_a = w[0];
      f_le_b = w[1];
      if (state == CMP) begin
         if (desc_q) begin
            f_le_a = w[j_nx];
            f_le_b = w[j];
         end else begin
            f_le_a = w[j];
            f_le_b = w[j_nx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w          <= '0;
         j          <= '0;
         p          <= '0;
         swapped    <= 1'b0;
         desc_q     <= 1'b0;
         err_sticky <= 1'b0;
         sorted     <= '0;
         err        <= 1'b0;
         valid_out  <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         case (state)
            IDLE: begin
               if (valid_in) begin
                  w          <= unsorted;
                  desc_q     <= descending;
                  j          <= '0;
                  p          <= '0;
                  swapped    <= 1'b0;
                  err_sticky <= 1'b0;
               end
            end
            CMP: begin
               if (f_le_err) begin
                  err_sticky <= 1'b1;
               end else begin
                  if (swap) begin
                     w[j]    <= w[j_nx];
                     w[j_nx] <= w[j];
                  end
                  if (last_pair) begin
                     p       <= p + JW'(1);
                     j       <= '0;
                     swapped <= 1'b0;
                  end else begin
                     j       <= j_nx;
                     swapped <= swapped | swap;
                  end
               end
            end
            DONE: begin
               sorted    <= w;
               err       <= err_sticky;
               valid_out <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sort_floats_n_using_fsm.sv
// Self-checking bench: three sorter instances (N=4, N=2, N=8) against a queue-level sort model.
module tb_sort_floats_n_using_fsm;

   typedef logic [63:0] vec_t [16];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        vin [3];
   logic        dsc [3];
   logic        vout [3];
   logic        verr [3];
   logic        vbusy [3];
   logic [63:0] fa [3];
   logic [63:0] fb [3];
   logic        fres [3];
   logic        ferr [3];

   logic [0:3][63:0] u4, s4;
   logic [0:1][63:0] u2, s2;
   logic [0:7][63:0] u8, s8;

   function automatic logic is_nan(input logic [63:0] x);
      return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
   endfunction

   // Comparator model: {a <= b, unordered}
   function automatic logic [1:0] fle(input logic [63:0] a, input logic [63:0] b);
      logic e;
      e = is_nan(a) || is_nan(b);
      if (e) return 2'b01;
      return {($bitstoreal(a) <= $bitstoreal(b)), 1'b0};
   endfunction

   assign {fres[0], ferr[0]} = fle(fa[0], fb[0]);
   assign {fres[1], ferr[1]} = fle(fa[1], fb[1]);
   assign {fres[2], ferr[2]} = fle(fa[2], fb[2]);

   sort_floats_n_using_fsm #(.N(4)) dut4 (
      .clk(clk), .rst(rst), .valid_in(vin[0]), .descending(dsc[0]), .unsorted(u4),
      .valid_out(vout[0]), .sorted(s4), .err(verr[0]), .busy(vbusy[0]),
      .f_le_a(fa[0]), .f_le_b(fb[0]), .f_le_res(fres[0]), .f_le_err(ferr[0]));

   sort_floats_n_using_fsm #(.N(2)) dut2 (
      .clk(clk), .rst(rst), .valid_in(vin[1]), .descending(dsc[1]), .unsorted(u2),
      .valid_out(vout[1]), .sorted(s2), .err(verr[1]), .busy(vbusy[1]),
      .f_le_a(fa[1]), .f_le_b(fb[1]), .f_le_res(fres[1]), .f_le_err(ferr[1]));

   sort_floats_n_using_fsm #(.N(8)) dut8 (
      .clk(clk), .rst(rst), .valid_in(vin[2]), .descending(dsc[2]), .unsorted(u8),
      .valid_out(vout[2]), .sorted(s8), .err(verr[2]), .busy(vbusy[2]),
      .f_le_a(fa[2]), .f_le_b(fb[2]), .f_le_res(fres[2]), .f_le_err(ferr[2]));

   function automatic int nn(input int k);
      return (k == 0) ? 4 : (k == 1) ? 2 : 8;
   endfunction

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc %0d: got %h expected %h", name, k, cyc, act, exp);
      end
   endtask

   // Reference: the spec's bubble sort over a plain array, with early exit and abort on NaN.
   task automatic model(input int n, input logic d, input vec_t v,
                        output vec_t r, output int c, output logic e);
      logic [63:0] x, y, t;
      logic sw;
      r = v; c = 0; e = 1'b0;
      for (int p = 0; p <= n - 2; p++) begin
         sw = 1'b0;
         for (int j = 0; j <= n - 2 - p; j++) begin
            x = d ? r[j+1] : r[j];
            y = d ? r[j]   : r[j+1];
            c++;
            if (is_nan(x) || is_nan(y)) begin
               e = 1'b1;
               return;
            end
            if (!($bitstoreal(x) <= $bitstoreal(y))) begin
               t = r[j]; r[j] = r[j+1]; r[j+1] = t; sw = 1'b1;
            end
         end
         if (!sw) return;
      end
   endtask

   // Expected-transaction records and the held output state per instance
   logic active [3];
   int   ts [3];
   int   tc [3];
   vec_t exp_res [3];
   logic exp_err [3];
   vec_t held [3];
   logic held_err [3];

   task automatic clear_model();
      for (int k = 0; k < 3; k++) begin
         active[k] = 1'b0;
         held_err[k] = 1'b0;
         for (int i = 0; i < 16; i++) held[k][i] = '0;
      end
   endtask

   always @(posedge clk) begin : mon
      vec_t s;
      logic eb, ev;
      #1;
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) s[i] = '0;
         case (k)
            0: for (int i = 0; i < 4; i++) s[i] = s4[i];
            1: for (int i = 0; i < 2; i++) s[i] = s2[i];
            default: for (int i = 0; i < 8; i++) s[i] = s8[i];
         endcase
         eb = active[k] && (cyc >= ts[k] + 1) && (cyc <= ts[k] + tc[k] + 1);
         ev = active[k] && (cyc == ts[k] + tc[k] + 2);
         if (ev) begin
            held[k] = exp_res[k];
            held_err[k] = exp_err[k];
         end
         chk("busy", k, 64'(vbusy[k]), 64'(eb));
         chk("valid_out", k, 64'(vout[k]), 64'(ev));
         chk("err", k, 64'(verr[k]), 64'(held_err[k]));
         for (int i = 0; i < nn(k); i++) chk("sorted", k, s[i], held[k][i]);
      end
   end

   task automatic start(input int k, input vec_t v, input logic d);
      vec_t r; int c; logic e;
      @(negedge clk);
      case (k)
         0: for (int i = 0; i < 4; i++) u4[i] = v[i];
         1: for (int i = 0; i < 2; i++) u2[i] = v[i];
         default: for (int i = 0; i < 8; i++) u8[i] = v[i];
      endcase
      dsc[k] = d;
      vin[k] = 1'b1;
      model(nn(k), d, v, r, c, e);
      exp_res[k] = r; tc[k] = c; exp_err[k] = e; ts[k] = cyc; active[k] = 1'b1;
      @(negedge clk);
      vin[k] = 1'b0;
   endtask

   task automatic finish_txn(input int k);
      while (cyc < ts[k] + tc[k] + 3) @(negedge clk);
   endtask

   function automatic vec_t mk4(input real a, input real b, input real c, input real d);
      vec_t v;
      for (int i = 0; i < 16; i++) v[i] = '0;
      v[0] = $realtobits(a); v[1] = $realtobits(b);
      v[2] = $realtobits(c); v[3] = $realtobits(d);
      return v;
   endfunction

   // Pins the model to hand-computed results, then runs the vector through the N=4 sorter.
   task automatic directed(input string name, input vec_t v, input logic d,
                           input vec_t lit, input int lit_c, input logic lit_e);
      vec_t r; int c; logic e;
      model(4, d, v, r, c, e);
      for (int i = 0; i < 4; i++) chk({name, "_lit"}, 0, r[i], lit[i]);
      chk({name, "_C"}, 0, 64'(c), 64'(lit_c));
      chk({name, "_e"}, 0, 64'(e), 64'(lit_e));
      start(0, v, d);
      finish_txn(0);
   endtask

   initial begin
      vec_t v, lit;
      logic [63:0] nan;
      nan = 64'h7FF8_0000_0000_0000;
      for (int k = 0; k < 3; k++) begin
         vin[k] = 1'b0; dsc[k] = 1'b0;
      end
      u4 = '0; u2 = '0; u8 = '0;
      clear_model();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      directed("rev", mk4(4.0, 3.0, 2.0, 1.0), 1'b0, mk4(1.0, 2.0, 3.0, 4.0), 6, 1'b0);
      directed("inord", mk4(1.0, 2.0, 2.0, 5.0), 1'b0, mk4(1.0, 2.0, 2.0, 5.0), 3, 1'b0);
      directed("desc", mk4(-1.0, 0.5, 3.0, -2.0), 1'b1, mk4(3.0, 0.5, -1.0, -2.0), 6, 1'b0);
      v = mk4(1.0, 0.0, 3.0, 2.0); v[1] = nan;
      directed("nan", v, 1'b0, v, 1, 1'b1);

      // Second request while busy must be dropped
      start(0, mk4(8.0, 7.0, 6.0, 5.0), 1'b0);
      @(negedge clk);
      u4 = '0; vin[0] = 1'b1;
      @(negedge clk);
      vin[0] = 1'b0;
      finish_txn(0);
      repeat (2) @(negedge clk);

      // Reset two cycles after accept discards the transaction
      start(0, mk4(9.0, 1.0, 8.0, 2.0), 1'b1);
      @(negedge clk);
      rst = 1'b1;
      clear_model();
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int r = 0; r < 200; r++) begin
         for (int k = 1; k < 3; k++) begin
            for (int i = 0; i < 16; i++)
               v[i] = (i < nn(k)) ? $realtobits((real'($urandom_range(0, 40)) - 20.0) / 4.0) : 64'd0;
            start(k, v, 1'($urandom_range(0, 1)));
            finish_txn(k);
         end
      end

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sort_floats_n_using_fsm.md
# sort_floats_n_using_fsm

Sequential sorter for N floating-point values using a single external `f_less_or_equal` comparator, one comparison per clock. It generalises the three-element FSM sorter to any `N >= 2`. It adds a per-transaction ascending/descending mode, early termination when a pass makes no swap, and abort-on-error. It sits between a producer that issues a vector with `valid_in` and a consumer that samples `sorted` on the `valid_out` pulse.

## Interface
- `N`, 4: number of elements; legal range 2..16.
- `FLEN`: element width, from the shared config header (FP64, 64 bits); not a module parameter.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `valid_in`  in  1  request; accepted only in IDLE.
- `descending`  in  1  mode; latched on accept (0 = ascending, 1 = descending).
- `unsorted`  in  [0:N-1][FLEN-1:0]  input vector; latched on accept.
- `valid_out`  out  1  one-cycle pulse; `sorted` and `err` are valid in this cycle.
- `sorted`  out  [0:N-1][FLEN-1:0]  result; held until the next accept.
- `err`  out  1  comparator error seen during the transaction; held with `sorted`.
- `busy`  out  1  high whenever state != IDLE.
- `f_le_a`, `f_le_b`  out  FLEN  comparator operands; combinational from the working array and the current index.
- `f_le_res`, `f_le_err`  in  1  combinational comparator result for the current `f_le_a`/`f_le_b`.

## Operation
- **Algorithm.** Bubble sort on an internal working array `w[0:N-1]`.
  - Pass `p` compares index pairs `(j, j+1)` for `j = 0 .. N-2-p`.
  - Each CMP cycle performs exactly one comparison.
- **Operand selection.**
  - Ascending: `f_le_a = w[j]`, `f_le_b = w[j+1]`; swap when `!f_le_res`.
  - Descending: `f_le_a = w[j+1]`, `f_le_b = w[j]`; swap when `!f_le_res`.
  - Equal elements never swap, so the sort is stable.
- **States:** IDLE, CMP, DONE.
  - IDLE: when `valid_in`, load `w <= unsorted`, latch the mode, set `p=0`, `j=0`, `swapped=0`, and go to CMP. Otherwise stay in IDLE.
  - CMP, when `f_le_err`: set the sticky error, leave `w` unchanged, go to DONE (abort).
  - CMP, not the last pair of the pass: conditionally swap, set `swapped |= swap`, `j++`.
  - CMP, last pair of the pass: if this is the final pass (`p == N-2`), or no swap occurred anywhere in the pass including this cycle, go to DONE. Otherwise `p++`, `j=0`, `swapped=0`.
  - DONE: `sorted <= w`, `err <=` sticky error, pulse `valid_out`, then go to IDLE.
- **Ignored inputs.** `valid_in` is ignored while `busy`. There is no queue and no backpressure.
- **Widths.**
  - `j` and `p` are `$clog2(N)` bits.
  - The comparison counter `C` used in the timing rules is not required in RTL.
- **Reset values.** `valid_out=0`, `err=0`, `sorted=0`, `busy=0`; state IDLE; sticky error 0.
- **Reset mid-operation** discards the transaction. No `valid_out` is produced for it.

## Timing
- Accept occurs at cycle `t` (IDLE and `valid_in`).
- CMP occupies cycles `t+1 .. t+C`, where `C` is the number of comparisons performed.
- DONE occurs at cycle `t+C+1`. `valid_out`, `sorted` and `err` update at the end of that cycle, so they are visible from `t+C+2` with `valid_out` high for exactly one cycle.
- The next accept is possible at `t+C+2`, the same cycle `valid_out` is seen.
- `C` bounds:
  - Minimum is `N-1` (input already in order).
  - Maximum is `N(N-1)/2` (reversed input).
  - On error, `C` is the index of the failing comparison (1-based).
- `busy` is high from `t+1` through `t+C+1`.
- `f_le_a`/`f_le_b` are don't-care outside CMP but must be driven, not X; they hold `w[0]`/`w[1]`.

## Structure
- Shared package `sort_fsm_pkg` holds the `sort_state_t` enum (IDLE, CMP, DONE). The next-pass and done conditions are computed inline.
- No sub-modules. The comparator is external and reached only through the `f_le_*` ports.
- Split into a state register, next-state logic, and a datapath `always_ff` that updates `w`, `j`, `p` and `swapped`.

## Test plan
- N=4, ascending, input {4.0, 3.0, 2.0, 1.0} → {1.0, 2.0, 3.0, 4.0}, `err=0`, `valid_out` visible at `t+8` (`C=6`).
- N=4, ascending, input {1.0, 2.0, 2.0, 5.0} → unchanged, `C=3`, `valid_out` visible at `t+5`; no swap of the equal elements.
- N=4, descending, input {-1.0, 0.5, 3.0, -2.0} → {3.0, 0.5, -1.0, -2.0}, `err=0`.
- N=4, NaN in slot 1 with the model asserting `f_le_err` → `err=1` and `valid_out` visible at `t+3`, `sorted` equal to the input, `busy` low at `t+3`.
- `valid_in` pulsed at `t+2` while busy → ignored: exactly one `valid_out`, the second vector never appears. `rst` at `t+2` → no `valid_out`, all outputs 0, `busy` 0.
- N=2 and N=8, 200 random FP64 vectors, each with a random mode → results match the reference sort, `busy` holds for exactly `C+1` cycles, and one `valid_out` per accept.
